// File: rtl/rwl_bitserial_seq_if.sv
// Handshake and bit-stream bundle between the activation source, the RWL sequencer
// and the downstream shift-add accumulator.
interface rwl_bitserial_seq_if #(
    parameter int unsigned N_ROW = 8,
    parameter int unsigned XBITS = 12
);
    localparam int unsigned W = N_ROW * XBITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         acc_ready;
    logic         swap_req;
    logic         swap_ack;
    logic [W-1:0] xin;
    logic [5:0]   sel;
    logic         cima;
    logic         bit_valid;
    logic         bit_msb;
    logic         bit_last;
    logic         busy;

    modport master (
        output in_valid, in_data, acc_ready, swap_req,
        input  in_ready, swap_ack, xin, sel, cima, bit_valid, bit_msb, bit_last, busy
    );

    modport slave (
        input  in_valid, in_data, acc_ready, swap_req,
        output in_ready, swap_ack, xin, sel, cima, bit_valid, bit_msb, bit_last, busy
    );
endinterface

// File: rtl/rwl_bitserial_seq.sv
// Bit-serial read-wordline sequencer: buffers one activation vector, streams it MSB first
// and owns the ping-pong compute-row flag (cima), toggled only at sweep boundaries.
module rwl_bitserial_seq #(
    parameter int unsigned N_ROW = 8,
    parameter int unsigned XBITS = 12
) (
    input  logic                clk,
    input  logic                rstn,
    rwl_bitserial_seq_if.slave  bus
);
    localparam int unsigned W        = N_ROW * XBITS;
    localparam int unsigned SELW     = 6;
    localparam logic [SELW-1:0] SEL_LAST = SELW'(XBITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state_q,     state_n;
    logic [W-1:0]    xin_q,       xin_n;
    logic [W-1:0]    nxt_q,       nxt_n;
    logic            nxt_vld_q,   nxt_vld_n;
    logic [SELW-1:0] sel_q,       sel_n;
    logic            cima_q,      cima_n;
    logic            swap_pend_q, swap_pend_n;
    logic            swap_ack_q,  swap_ack_n;
    logic            bit_valid_q, bit_valid_n;
    logic            accept;
    logic            boundary;

    // in_ready only looks at the pending-buffer flag, never at acc_ready
    assign accept = bus.in_valid && !nxt_vld_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            xin_q       <= '0;
            nxt_q       <= '0;
            nxt_vld_q   <= 1'b0;
            sel_q       <= '0;
            cima_q      <= 1'b1;
            swap_pend_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            xin_q       <= xin_n;
            nxt_q       <= nxt_n;
            nxt_vld_q   <= nxt_vld_n;
            sel_q       <= sel_n;
            cima_q      <= cima_n;
            swap_pend_q <= swap_pend_n;
            swap_ack_q  <= swap_ack_n;
            bit_valid_q <= bit_valid_n;
        end
    end

    // Next-state, sweep stepping and swap arbitration
    always_comb begin
        state_n     = state_q;
        xin_n       = xin_q;
        nxt_n       = nxt_q;
        nxt_vld_n   = nxt_vld_q;
        sel_n       = sel_q;
        cima_n      = cima_q;
        swap_pend_n = swap_pend_q | bus.swap_req;
        swap_ack_n  = 1'b0;
        boundary    = 1'b0;

        if (accept) begin
            nxt_n     = bus.in_data;
            nxt_vld_n = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                boundary = 1'b1;
                if (nxt_vld_q) begin
                    xin_n     = nxt_q;
                    sel_n     = '0;
                    nxt_vld_n = 1'b0;
                    state_n   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.acc_ready) begin
                    if (sel_q == SEL_LAST) begin
                        boundary = 1'b1;
                        sel_n    = '0;
                        if (nxt_vld_q) begin
                            xin_n     = nxt_q;
                            nxt_vld_n = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        sel_n = SELW'(sel_q + SELW'(1));
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A request arriving on the toggle edge stays pending for the next boundary
        if (boundary && swap_pend_q) begin
            cima_n      = ~cima_q;
            swap_ack_n  = 1'b1;
            swap_pend_n = bus.swap_req;
        end

        bit_valid_n = (state_n == S_RUN);
    end

    assign bus.in_ready  = rstn && !nxt_vld_q;
    assign bus.xin       = xin_q;
    assign bus.sel       = sel_q;
    assign bus.cima      = cima_q;
    assign bus.swap_ack  = swap_ack_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_msb   = bit_valid_q && (sel_q == '0);
    assign bus.bit_last  = bit_valid_q && (sel_q == SEL_LAST);
    assign bus.busy      = (state_q == S_RUN) || nxt_vld_q;
endmodule
